// File: rtl/ahb3lite_cmd_master.sv
// ahb3lite_cmd_master
// Single-master AHB-Lite command engine. Commands arrive on a valid/ready
// port, are held in an address-phase stage (AP) until the bus accepts them,
// then move to a data-phase stage (DP). Address and data phases overlap, so
// one SINGLE transfer per cycle is sustained while HREADY stays high.
// Each completed data phase returns one in-order response.
module ahb3lite_cmd_master #(
  parameter int HADDR_SIZE = 8,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [1:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  // Replicate right-justified write data across all byte lanes.
  function automatic logic [HDATA_SIZE-1:0] replicate_lanes(
    input logic [1:0]            size,
    input logic [HDATA_SIZE-1:0] wdata
  );
    logic [HDATA_SIZE-1:0] r;
    case (size)
      2'd0:    r = {4{wdata[7:0]}};
      2'd1:    r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Pull the addressed lane(s) out of HRDATA, right-justified, zero-extended.
  function automatic logic [HDATA_SIZE-1:0] extract_lanes(
    input logic [1:0]            size,
    input logic [1:0]            a,
    input logic [HDATA_SIZE-1:0] rdata
  );
    logic [HDATA_SIZE-1:0] r;
    r = {HDATA_SIZE{1'b0}};
    case (size)
      2'd0:    r[7:0]  = rdata[{a, 3'b000} +: 8];
      2'd1:    r[15:0] = rdata[{a[1], 4'b0000} +: 16];
      default: r       = rdata;
    endcase
    return r;
  endfunction

  // Clear the low address bits that the transfer size makes meaningless.
  function automatic logic [HADDR_SIZE-1:0] align_addr(
    input logic [1:0]            size,
    input logic [HADDR_SIZE-1:0] addr
  );
    logic [HADDR_SIZE-1:0] r;
    case (size)
      2'd0:    r = addr;
      2'd1:    r = {addr[HADDR_SIZE-1:1], 1'b0};
      default: r = {addr[HADDR_SIZE-1:2], 2'b00};
    endcase
    return r;
  endfunction

  // Address-phase stage
  logic                  ap_valid_r;
  logic                  ap_write_r;
  logic [HADDR_SIZE-1:0] ap_addr_r;
  logic [1:0]            ap_size_r;
  logic [HDATA_SIZE-1:0] ap_wdata_r;

  // Data-phase stage
  logic                  dp_valid_r;
  logic                  dp_write_r;
  logic [1:0]            dp_addr_r;
  logic [1:0]            dp_size_r;
  logic [HDATA_SIZE-1:0] dp_wdata_r;

  logic       err_hold_s;
  logic       issue_s;
  logic       accept_s;
  logic       complete_s;
  logic [1:0] size_norm_s;

  // Handshake terms and bus-facing outputs derived from the two stages.
  always_comb begin
    err_hold_s  = dp_valid_r & HRESP;
    issue_s     = ap_valid_r & HREADY & ~err_hold_s;
    complete_s  = dp_valid_r & HREADY;
    cmd_ready   = ~HRESET & (~ap_valid_r | issue_s);
    accept_s    = cmd_valid & cmd_ready;
    // Size 3 is not a legal command size; fold it onto word.
    if (cmd_size == 2'd3) begin
      size_norm_s = 2'd2;
    end else begin
      size_norm_s = cmd_size;
    end
    // The first ERROR cycle must drop the pending transfer to IDLE.
    if (ap_valid_r & ~err_hold_s) begin
      HTRANS = 2'b10;
    end else begin
      HTRANS = 2'b00;
    end
    HSEL   = HTRANS[1];
    HADDR  = align_addr(ap_size_r, ap_addr_r);
    HWRITE = ap_write_r;
    HSIZE  = {1'b0, ap_size_r};
    HBURST = 3'b000;
    HPROT  = 4'b0011;
    if (dp_valid_r) begin
      HWDATA = replicate_lanes(dp_size_r, dp_wdata_r);
    end else begin
      HWDATA = {HDATA_SIZE{1'b0}};
    end
    busy = ap_valid_r | dp_valid_r;
  end

  // Advance AP/DP and register the per-command response.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ap_valid_r <= 1'b0;
      ap_write_r <= 1'b0;
      ap_addr_r  <= {HADDR_SIZE{1'b0}};
      ap_size_r  <= 2'd0;
      ap_wdata_r <= {HDATA_SIZE{1'b0}};
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 2'd0;
      dp_size_r  <= 2'd0;
      dp_wdata_r <= {HDATA_SIZE{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= {HDATA_SIZE{1'b0}};
    end else begin
      if (accept_s) begin
        ap_valid_r <= 1'b1;
        ap_write_r <= cmd_write;
        ap_addr_r  <= cmd_addr;
        ap_size_r  <= size_norm_s;
        ap_wdata_r <= cmd_wdata;
      end else if (issue_s) begin
        ap_valid_r <= 1'b0;
      end
      // DP only moves on edges where the current data phase ends.
      if (HREADY) begin
        dp_valid_r <= issue_s;
        if (issue_s) begin
          dp_write_r <= ap_write_r;
          dp_addr_r  <= ap_addr_r[1:0];
          dp_size_r  <= ap_size_r;
          dp_wdata_r <= ap_wdata_r;
        end
      end
      rsp_valid <= complete_s;
      rsp_err   <= complete_s & HRESP;
      if (complete_s & ~dp_write_r & ~HRESP) begin
        rsp_rdata <= extract_lanes(dp_size_r, dp_addr_r, HRDATA);
      end else begin
        rsp_rdata <= {HDATA_SIZE{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_ahb3lite_cmd_master.sv
// Testbench for ahb3lite_cmd_master: directed commands against a small
// byte-addressed SRAM slave whose HREADY/HRESP are steered by the stimulus.
// Expected responses go into a scoreboard queue; a monitor pops and compares.
module tb_ahb3lite_cmd_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        HSEL;
  logic [7:0]  HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb3lite_cmd_master #(.HADDR_SIZE(8), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // SRAM slave model
  logic [7:0] mem [0:255];
  logic       s_v;
  logic       s_w;
  logic [7:0] s_a;
  logic [1:0] s_sz;
  logic [7:0] s_base;
  assign s_base = {s_a[7:2], 2'b00};
  assign HRDATA = {mem[s_base + 8'd3], mem[s_base + 8'd2], mem[s_base + 8'd1], mem[s_base]};

  always @(posedge HCLK) begin
    if (HRESET) begin
      s_v <= 1'b0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (HREADY) begin
      if (s_v && s_w && !HRESP) begin
        for (int i = 0; i < 4; i++) begin
          if (s_sz == 2'd2 || (s_sz == 2'd1 && i[1] == s_a[1]) ||
              (s_sz == 2'd0 && i[1:0] == s_a[1:0]))
            mem[s_base + 8'(i)] <= HWDATA[8*i +: 8];
        end
      end
      s_v  <= HTRANS[1];
      s_w  <= HWRITE;
      s_a  <= HADDR;
      s_sz <= HSIZE[1:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_cmd(input bit v, input bit w, input logic [7:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  task automatic push_exp(input logic [31:0] rd, input logic er, input int c);
    exp_t e;
    e.rdata = rd;
    e.err   = er;
    e.cyc   = c;
    sb.push_back(e);
  endtask

  // One isolated command with bus checks on its address and data phases.
  task automatic issue1(input string nm, input bit w, input logic [7:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic [7:0] ex_haddr, input logic [2:0] ex_hsize,
                        input logic [31:0] ex_hwdata, input logic [31:0] ex_rd);
    int c;
    c = cyc;
    set_cmd(1'b1, w, a, s, d);
    push_exp(ex_rd, 1'b0, c + 3);
    @(negedge HCLK);
    chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    step();
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    @(negedge HCLK);
    chk({nm, "_htrans"}, 32'(HTRANS), 32'd2);
    chk({nm, "_hsel"}, 32'(HSEL), 32'd1);
    chk({nm, "_haddr"}, 32'(HADDR), 32'(ex_haddr));
    chk({nm, "_hwrite"}, 32'(HWRITE), 32'(w));
    chk({nm, "_hsize"}, 32'(HSIZE), 32'(ex_hsize));
    step();
    @(negedge HCLK);
    chk({nm, "_dp_htrans"}, 32'(HTRANS), 32'd0);
    if (w) chk({nm, "_hwdata"}, HWDATA, ex_hwdata);
    step();
    step();
  endtask

  // Scoreboard monitor: every response pulse is matched against the queue head.
  always @(negedge HCLK) begin
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: actual=rsp_valid rdata=%0h err=%0b expected=no response (cycle %0d)",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        chk("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] bd [0:3];

  initial begin
    int c0;
    bd[0] = 32'hA0A1A2A3;
    bd[1] = 32'hB0B1B2B3;
    bd[2] = 32'hC0C1C2C3;
    bd[3] = 32'hD0D1D2D3;
    HRESET = 1'b1;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);

    // Reset values
    repeat (2) step();
    @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_hsel", 32'(HSEL), 32'd0);
    chk("rst_haddr", 32'(HADDR), 32'd0);
    chk("rst_hwrite", 32'(HWRITE), 32'd0);
    chk("rst_hsize", 32'(HSIZE), 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hburst", 32'(HBURST), 32'd0);
    chk("rst_hprot", 32'(HPROT), 32'd3);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);
    step();

    // Single write then read
    issue1("wr1", 1'b1, 8'h10, 2'd2, 32'hDEADBEEF, 8'h10, 3'd2, 32'hDEADBEEF, 32'h0);
    issue1("rd1", 1'b0, 8'h10, 2'd2, 32'h0, 8'h10, 3'd2, 32'h0, 32'hDEADBEEF);

    // Back-to-back: 4 writes then 4 reads, cmd_valid held high
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        set_cmd(1'b1, 1'b1, 8'(4 * i), 2'd2, bd[i]);
        push_exp(32'h0, 1'b0, c0 + i + 3);
      end else begin
        set_cmd(1'b1, 1'b0, 8'(4 * (i - 4)), 2'd2, 32'h0);
        push_exp(bd[i-4], 1'b0, c0 + i + 3);
      end
      @(negedge HCLK);
      chk("b2b_ready", 32'(cmd_ready), 32'd1);
      if (i > 0) begin
        chk("b2b_htrans", 32'(HTRANS), 32'd2);
        chk("b2b_haddr", 32'(HADDR), 32'(4 * ((i - 1) % 4)));
      end
      step();
    end
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    @(negedge HCLK);
    chk("b2b_htrans_last", 32'(HTRANS), 32'd2);
    chk("b2b_haddr_last", 32'(HADDR), 32'h0C);
    step();
    @(negedge HCLK);
    chk("b2b_idle", 32'(HTRANS), 32'd0);
    repeat (3) step();

    // Sub-word accesses (upper cmd_wdata bits must be ignored)
    issue1("sb_wrb", 1'b1, 8'h21, 2'd0, 32'hFFFFFFA5, 8'h21, 3'd0, 32'hA5A5A5A5, 32'h0);
    issue1("sb_wrh", 1'b1, 8'h23, 2'd1, 32'hABCD1234, 8'h22, 3'd1, 32'h12341234, 32'h0);
    issue1("sb_rdw", 1'b0, 8'h20, 2'd2, 32'h0, 8'h20, 3'd2, 32'h0, 32'h1234A500);
    issue1("sb_rdb", 1'b0, 8'h21, 2'd0, 32'h0, 8'h21, 3'd0, 32'h0, 32'h000000A5);
    issue1("sb_rdh", 1'b0, 8'h22, 2'd1, 32'h0, 8'h22, 3'd1, 32'h0, 32'h00001234);
    issue1("sb_rdb3", 1'b0, 8'h23, 2'd0, 32'h0, 8'h23, 3'd0, 32'h0, 32'h00000012);

    // Illegal size 3 behaves as word
    issue1("sz3_wr", 1'b1, 8'h31, 2'd3, 32'h55667788, 8'h30, 3'd2, 32'h55667788, 32'h0);
    issue1("sz3_rd", 1'b0, 8'h33, 2'd3, 32'h0, 8'h30, 3'd2, 32'h0, 32'h55667788);

    // Wait states: two HREADY-low cycles in a read's data phase
    c0 = cyc;
    set_cmd(1'b1, 1'b0, 8'h04, 2'd2, 32'h0);
    push_exp(bd[1], 1'b0, c0 + 5);
    @(negedge HCLK);
    chk("ws_ready0", 32'(cmd_ready), 32'd1);
    step();
    set_cmd(1'b1, 1'b0, 8'h08, 2'd2, 32'h0);
    push_exp(bd[2], 1'b0, c0 + 6);
    @(negedge HCLK);
    chk("ws_ready1", 32'(cmd_ready), 32'd1);
    chk("ws_haddr1", 32'(HADDR), 32'h04);
    step();
    HREADY = 1'b0;
    set_cmd(1'b1, 1'b0, 8'h0C, 2'd2, 32'h0);
    push_exp(bd[3], 1'b0, c0 + 7);
    for (int k = 0; k < 2; k++) begin
      @(negedge HCLK);
      chk("ws_hold_ready", 32'(cmd_ready), 32'd0);
      chk("ws_hold_htrans", 32'(HTRANS), 32'd2);
      chk("ws_hold_haddr", 32'(HADDR), 32'h08);
      step();
    end
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("ws_resume_ready", 32'(cmd_ready), 32'd1);
    chk("ws_resume_haddr", 32'(HADDR), 32'h08);
    step();
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    @(negedge HCLK);
    chk("ws_next_haddr", 32'(HADDR), 32'h0C);
    chk("ws_next_htrans", 32'(HTRANS), 32'd2);
    repeat (3) step();

    // Two-cycle ERROR on a write while a read waits in AP
    c0 = cyc;
    set_cmd(1'b1, 1'b1, 8'h40, 2'd2, 32'h99999999);
    push_exp(32'h0, 1'b1, c0 + 4);
    @(negedge HCLK);
    chk("er_ready0", 32'(cmd_ready), 32'd1);
    step();
    set_cmd(1'b1, 1'b0, 8'h04, 2'd2, 32'h0);
    push_exp(bd[1], 1'b0, c0 + 6);
    @(negedge HCLK);
    chk("er_ready1", 32'(cmd_ready), 32'd1);
    chk("er_wr_haddr", 32'(HADDR), 32'h40);
    step();
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    @(negedge HCLK);
    chk("er_c1_htrans", 32'(HTRANS), 32'd0);
    chk("er_c1_hsel", 32'(HSEL), 32'd0);
    chk("er_c1_busy", 32'(busy), 32'd1);
    step();
    HREADY = 1'b1;
    @(negedge HCLK);
    chk("er_c2_htrans", 32'(HTRANS), 32'd0);
    step();
    HRESP = 1'b0;
    @(negedge HCLK);
    chk("er_re_htrans", 32'(HTRANS), 32'd2);
    chk("er_re_haddr", 32'(HADDR), 32'h04);
    chk("er_re_hwrite", 32'(HWRITE), 32'd0);
    step();
    @(negedge HCLK);
    chk("er_after_htrans", 32'(HTRANS), 32'd0);
    repeat (3) step();

    // Reset with both AP and DP occupied
    set_cmd(1'b1, 1'b1, 8'h50, 2'd2, 32'h11223344);
    @(negedge HCLK);
    chk("rm_ready0", 32'(cmd_ready), 32'd1);
    step();
    set_cmd(1'b1, 1'b0, 8'h54, 2'd2, 32'h0);
    @(negedge HCLK);
    chk("rm_ready1", 32'(cmd_ready), 32'd1);
    step();
    set_cmd(1'b0, 1'b0, 8'h00, 2'd0, 32'h0);
    HRESET = 1'b1;
    @(negedge HCLK);
    chk("rm_busy_before", 32'(busy), 32'd1);
    chk("rm_ready_in_rst", 32'(cmd_ready), 32'd0);
    step();
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rm_htrans", 32'(HTRANS), 32'd0);
    chk("rm_busy", 32'(busy), 32'd0);
    repeat (6) step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
